// File: rtl/speck_round_key_store.sv
// speck_round_key_store: SPECK128/128 key expander with round-key store; SPECK_RKS_BIDIR_EN adds dir-selectable encrypt order
`ifndef NR_ROUNDS
`define NR_ROUNDS 32
`endif

module speck_round_key_store #(
    parameter int NR_ROUNDS = `NR_ROUNDS,
    parameter int IDX_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [127:0]     key,
    input  logic             key_valid,
    output logic             key_ready,
`ifdef SPECK_RKS_BIDIR_EN
    input  logic             dir,
`endif
    output logic [63:0]      rk,
    output logic [IDX_W-1:0] rk_idx,
    output logic             rk_last,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy
);
    localparam int AW = $clog2(NR_ROUNDS);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(NR_ROUNDS - 1);
    localparam logic [IDX_W-1:0] PENULT = IDX_W'(NR_ROUNDS - 2);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t state, state_nxt;
    logic [63:0] k_q, l_q, k_nxt, l_nxt;
    logic [63:0] store [NR_ROUNDS];
    logic [IDX_W-1:0] cnt, cnt_inc, ptr, ptr_nxt, start, fin;
    logic dec, key_acc, rk_acc, exp_done, at_last;

`ifdef SPECK_RKS_BIDIR_EN
    logic dir_q;
    always_ff @(posedge clk) begin
        if (key_acc) dir_q <= dir;
    end
    assign dec = dir_q;
`else
    assign dec = 1'b1;
`endif

    always_comb begin
        l_nxt     = (k_q + {l_q[7:0], l_q[63:8]}) ^ 64'(cnt);
        k_nxt     = {k_q[60:0], k_q[63:61]} ^ l_nxt;
        cnt_inc   = cnt + 1'b1;
        start     = dec ? LAST : '0;
        fin       = dec ? '0 : LAST;
        busy      = state == EXPAND;
        rk_valid  = state == READY;
        key_ready = state == IDLE || (rk_valid && ptr == start);
        key_acc   = key_valid && key_ready;
        rk_acc    = rk_valid && rk_ready;
        exp_done  = busy && cnt == PENULT;
        at_last   = ptr == fin;
        rk_last   = rk_valid && at_last;
        rk_idx    = rk_valid ? ptr : '0;
        rk        = rk_valid ? store[ptr[AW-1:0]] : '0;
        ptr_nxt   = at_last ? start : dec ? ptr - 1'b1 : ptr + 1'b1;
        state_nxt = key_acc ? EXPAND : exp_done ? READY : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            ptr <= '0;
        end else begin
            if (key_acc) cnt <= '0;
            else if (busy) cnt <= cnt_inc;
            if (exp_done) ptr <= start;
            else if (rk_acc) ptr <= ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (key_acc) begin
            k_q      <= key[127:64];
            l_q      <= key[63:0];
            store[0] <= key[127:64];
        end else if (busy) begin
            k_q                   <= k_nxt;
            l_q                   <= l_nxt;
            store[cnt_inc[AW-1:0]] <= k_nxt;
        end
    end
endmodule

// File: tb/tb_speck_round_key_store.sv
// tb_speck_round_key_store: directed self-checking bench for speck_round_key_store
module tb_speck_round_key_store;
    localparam logic [127:0] KAT = 128'h0706050403020100_0f0e0d0c0b0a0908;
    localparam logic [127:0] K2  = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] K3  = 128'hdeadbeefcafef00d_0badc0de12345678;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [127:0] key = '0;
    logic key_valid = 1'b0;
    logic key_ready;
`ifdef SPECK_RKS_BIDIR_EN
    logic dir = 1'b1;
`endif
    logic [63:0] rk;
    logic [5:0] rk_idx;
    logic rk_last, rk_valid, busy;
    logic rk_ready = 1'b0;

    int n_assert = 0;
    int n_fail = 0;
    logic [63:0] mk [32];

    always #5 clk = ~clk;

    speck_round_key_store dut (
        .clk(clk),
        .rst_n(rst_n),
        .key(key),
        .key_valid(key_valid),
        .key_ready(key_ready),
`ifdef SPECK_RKS_BIDIR_EN
        .dir(dir),
`endif
        .rk(rk),
        .rk_idx(rk_idx),
        .rk_last(rk_last),
        .rk_valid(rk_valid),
        .rk_ready(rk_ready),
        .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_key_ready"}, 64'(key_ready), 64'd1);
        chk({tag, "_rk_valid"}, 64'(rk_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rk_last"}, 64'(rk_last), 64'd0);
        chk({tag, "_rk_idx"}, 64'(rk_idx), 64'd0);
        chk({tag, "_rk"}, rk, 64'd0);
    endtask

    task automatic gen(input logic [127:0] k);
        logic [63:0] a, b;
        a = k[127:64];
        b = k[63:0];
        mk[0] = a;
        for (int i = 1; i < 32; i++) begin
            b = (a + {b[7:0], b[63:8]}) ^ 64'(i - 1);
            a = {a[60:0], a[63:61]} ^ b;
            mk[i] = a;
        end
    endtask

    task automatic load(input logic [127:0] k);
        key = k;
        key_valid = 1'b1;
        rk_ready = 1'b0;
        chk("load_key_ready", 64'(key_ready), 64'd1);
        tick;
        key_valid = 1'b0;
        gen(k);
    endtask

    task automatic wait_expand(input logic [5:0] first);
        int lat = 0;
        int bc = 0;
        while (!rk_valid && lat < 100) begin
            if (busy) bc++;
            tick;
            lat++;
        end
        chk("expand_latency", 64'(lat), 64'd31);
        chk("expand_busy_cycles", 64'(bc), 64'd31);
        chk("expand_first_idx", 64'(rk_idx), 64'(first));
        chk("expand_busy_clear", 64'(busy), 64'd0);
    endtask

    task automatic stream(input bit dec, input bit bp, input bit kat, input int key_at, input logic [127:0] nkey);
        int beat = 0;
        int cyc = 0;
        int e;
        bit stalled = 1'b0;
        logic [63:0] prk = '0;
        logic [5:0] pidx = '0;
        while (beat < 32 && cyc < 2000) begin
            rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (beat == key_at) begin
                key = nkey;
                key_valid = 1'b1;
            end
            if (stalled) begin
                chk("hold_rk", rk, prk);
                chk("hold_idx", 64'(rk_idx), 64'(pidx));
            end
            if (rk_valid && rk_ready) begin
                e = dec ? 31 - beat : beat;
                chk("beat_idx", 64'(rk_idx), 64'(e));
                chk("beat_rk", rk, mk[e]);
                chk("beat_last", 64'(rk_last), 64'(beat == 31));
                chk("beat_key_ready", 64'(key_ready), 64'(beat == 0));
                if (key_valid) chk("rekey_ignored_busy", 64'(busy), 64'd0);
                if (kat && e == 1) chk("kat_rk1", rk, 64'h37253b31171d0309);
                if (kat && e == 0) chk("kat_rk0", rk, 64'h0706050403020100);
                beat++;
                stalled = 1'b0;
            end else begin
                stalled = rk_valid;
                prk = rk;
                pidx = rk_idx;
            end
            tick;
            cyc++;
        end
        chk("stream_beats", 64'(beat), 64'd32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) begin
            tick;
            chk_idle("reset");
        end
        rst_n = 1'b1;
        repeat (3) begin
            tick;
            chk_idle("idle");
        end
        load(KAT);
        wait_expand(6'd31);
        stream(1'b1, 1'b0, 1'b1, -1, '0);
        stream(1'b1, 1'b0, 1'b1, -1, '0);
        stream(1'b1, 1'b1, 1'b1, -1, '0);
        stream(1'b1, 1'b0, 1'b1, 5, K2);
        rk_ready = 1'b0;
        chk("rekey_key_ready", 64'(key_ready), 64'd1);
        tick;
        key_valid = 1'b0;
        gen(K2);
        wait_expand(6'd31);
        stream(1'b1, 1'b0, 1'b0, -1, '0);
        load(K3);
        repeat (9) tick;
        chk("mid_expand_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick;
        chk_idle("mid_reset");
        rst_n = 1'b1;
        tick;
        chk_idle("post_reset");
        load(KAT);
        wait_expand(6'd31);
        stream(1'b1, 1'b1, 1'b1, -1, '0);
`ifdef SPECK_RKS_BIDIR_EN
        dir = 1'b0;
        load(KAT);
        wait_expand(6'd0);
        stream(1'b0, 1'b0, 1'b1, -1, '0);
        stream(1'b0, 1'b1, 1'b1, -1, '0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/speck_round_key_store.md
# speck_round_key_store

- Iterative SPECK128/128 key expander with an on-chip round-key store.
- Accepts one 128-bit master key, expands all `NR_ROUNDS` 64-bit round keys at one per cycle and holds them.
- Streams the round keys over a valid/ready interface, in decrypt order (k[NR_ROUNDS-1] first) by default.
- Sits directly upstream of the decrypt round datapath. It replaces the per-round key_schedule chain, so the round logic consumes one key per round without recomputing the schedule for each block.

## Interface
- `NR_ROUNDS`, default `` `NR_ROUNDS `` from cipher_settings.vh (32): number of round keys expanded and stored.
- `IDX_W`, default 6: width of the round-index outputs; must satisfy 2^IDX_W ≥ NR_ROUNDS.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `key`  in  128  master key; `key[127:64]` = k0, `key[63:0]` = l0.
- `key_valid`  in  1  master key offered.
- `key_ready`  out  1  store can accept a new key.
- `dir`  in  1  sampled with the key: 1 = decrypt order, 0 = encrypt order (see Configuration).
- `rk`  out  64  current round key.
- `rk_idx`  out  IDX_W  round index of `rk` (0..NR_ROUNDS-1).
- `rk_last`  out  1  current beat is the final key of the sequence.
- `rk_valid`  out  1  `rk` is valid.
- `rk_ready`  in  1  consumer takes `rk` this cycle.
- `busy`  out  1  expansion in progress.

## Operation

State machine: IDLE, EXPAND, READY.

**Reset** (`rst_n` = 0 at an edge):
- State goes to IDLE; expansion counter and stream pointer clear to 0.
- Outputs: `key_ready` = 1, `rk_valid` = 0, `busy` = 0, `rk_last` = 0, `rk_idx` = 0, `rk` = 0.
- Store contents are don't-care and are never exposed before a new expansion completes.
- Reset mid-EXPAND or mid-stream aborts immediately.

**IDLE**
- `key_ready` = 1.
- On `key_valid & key_ready`: register k0/l0, write store[0] = k0, latch `dir`, go to EXPAND with counter i = 0.

**EXPAND** (`busy` = 1, `key_ready` = 0, `rk_valid` = 0)
- Each cycle computes and writes store[i+1], then i increments:
  - l' = (k + ROR(l,8)) ^ i, with the addition mod 2^64 and i zero-extended to 64 bits.
  - k' = ROL(k,3) ^ l'.
- When store[NR_ROUNDS-1] is written, go to READY with the stream pointer at the first key of the latched order.

**READY**
- `rk_valid` = 1, `rk` = store[ptr], `rk_idx` = ptr.
- Decrypt order: ptr starts at NR_ROUNDS-1 and decrements. Encrypt order: ptr starts at 0 and increments.
- `rk_last` = 1 when ptr is the final index of the order (0 for decrypt, NR_ROUNDS-1 for encrypt).
- On `rk_valid & rk_ready`, ptr advances. After the last beat, ptr rewinds to the start index and stays in READY, so the keys replay for the next block.

**Rekeying**
- `key_ready` = 1 in READY only while ptr is at the start index (between blocks).
- A key accepted in READY restarts the sequence exactly as from IDLE.
- If `key_valid` and an `rk_ready` handshake coincide, only the rk handshake completes, because `key_ready` = 0 mid-stream.

## Timing
- Key accept edge E: store[0] is written at E. EXPAND occupies edges E+1 .. E+NR_ROUNDS-1.
- `rk_valid` rises after edge E+NR_ROUNDS-1, i.e. NR_ROUNDS-1 cycles after acceptance (31 for 32 rounds).
- `rk`, `rk_idx` and `rk_last` come from the registered ptr and stay stable while `rk_valid & !rk_ready`.
- Throughput: one round key per cycle with `rk_ready` held high. A full sequence takes NR_ROUNDS cycles.
- `key_valid` while `key_ready` = 0 is ignored. The source must hold it; it is not queued.

## Configuration
- `SPECK_RKS_BIDIR_EN` defined: the `dir` port exists and is latched at key acceptance; encrypt order is selectable.
- `SPECK_RKS_BIDIR_EN` undefined: the `dir` port is absent and the order is fixed to decrypt. `rk_last` marks index 0 and ptr rewinds to NR_ROUNDS-1.

## Test plan
- **Reset and idle.** Hold `rst_n` = 0 for 3 cycles, then release with no key. Required: `key_ready` = 1, `rk_valid` = 0, `busy` = 0 throughout.
- **Known-answer, decrypt order.** Stimulus: `key` = 0x0706050403020100_0f0e0d0c0b0a0908, `dir` = 1, `rk_ready` = 1. Required:
  - `rk_valid` rises 31 cycles after acceptance.
  - 32 beats follow with `rk_idx` 31..0.
  - Beat `rk_idx` = 1 carries 0x37253b31171d0309 and beat `rk_idx` = 0 carries 0x0706050403020100 with `rk_last` = 1.
  - All beats match the software model.
- **Backpressure.** Toggle `rk_ready` pseudo-randomly. Required: `rk`/`rk_idx` held while stalled, no beat skipped or duplicated, 32 beats per sequence.
- **Replay.** Consume two full sequences back to back. Required: identical 64-keys-total stream, with `key_ready` = 1 only between sequences.
- **Rekey and blocking.** Assert `key_valid` with a new key at beat 5. Required: ignored until after the `rk_last` beat, then accepted, with `busy` = 1 for 31 cycles and the new key sequence out.
- **Reset mid-EXPAND.** Assert `rst_n` = 0 at cycle 10 of expansion. Required: IDLE on the next edge with all outputs at reset values. A following key expands correctly.
- **Encrypt order** (`SPECK_RKS_BIDIR_EN` builds only). `dir` = 0 with the known-answer key. Required: first beat is `rk_idx` 0 = 0x0706050403020100, then 0x37253b31171d0309, with `rk_last` on index 31.
